// File: rtl/part2_4bit_counter_modern_pkg.sv
// -----------------------------------------------------------------------------
// part2_4bit_counter_modern_pkg
//
// Purpose : shared constants and types for the free-running up-counter and
//           for any block that consumes its count.
//
// Contents:
//   DEFAULT_WIDTH       - default counter width in bits (4)
//   DEFAULT_RESET_VALUE - default value loaded while reset is asserted (0)
//   count_t             - count word sized from DEFAULT_WIDTH
//   next_count()        - modulo-2^DEFAULT_WIDTH successor of a count word
// -----------------------------------------------------------------------------
package part2_4bit_counter_modern_pkg;

   localparam int unsigned DEFAULT_WIDTH       = 4;
   localparam int unsigned DEFAULT_RESET_VALUE = 0;

   typedef logic [DEFAULT_WIDTH-1:0] count_t;

   // Successor of a default-width count; the carry out of the MSB is dropped.
   function automatic count_t next_count(input count_t i_cur);
      return i_cur + count_t'(1);
   endfunction

endpackage : part2_4bit_counter_modern_pkg

// File: rtl/part2_4bit_counter_modern_counter_bit.sv
// -----------------------------------------------------------------------------
// counter_bit
//
// Purpose : one-bit slice of a synchronous binary up-counter. The bit toggles
//           on the rising clock edge when every lower bit is 1 (carry-in set)
//           and forwards carry-out = q & carry-in to the next slice up.
//
// Parameters:
//   RESET_BIT - value forced onto the bit while reset is asserted
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  asynchronous reset, active low
//   i_carry in   1  carry-in: all lower bits are 1 (tie to 1 for bit 0)
//   o_q     out  1  registered bit value
//   o_carry out  1  carry-out to the next slice
// -----------------------------------------------------------------------------
module counter_bit #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_carry,
   output logic o_q,
   output logic o_carry
);

   logic r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= RESET_BIT;
      end else if (i_carry) begin
         r_q <= ~r_q;
      end
   end

   // Carry chain is combinational, but every slice samples it on the same
   // edge, so all count bits still change together.
   assign o_carry = r_q & i_carry;
   assign o_q     = r_q;

endmodule : counter_bit

// File: rtl/part2_4bit_counter_modern.sv
// -----------------------------------------------------------------------------
// part2_4bit_counter_modern
//
// Purpose : free-running registered binary up-counter. Advances by one on each
//           rising clock edge, wraps from all-ones to zero, and is forced to
//           RESET_VALUE asynchronously while reset is low.
//
// Parameters:
//   WIDTH       - counter width in bits (default 4)
//   RESET_VALUE - value held while reset is asserted (default 0); must fit
//                 in WIDTH bits
//
// Ports:
//   clk  in   1      sole clock, rising edge
//   rst  in   1      asynchronous reset, active low (0 = reset asserted)
//   a    out  WIDTH  current count, driven straight from the slice flops
// -----------------------------------------------------------------------------
module part2_4bit_counter_modern
   import part2_4bit_counter_modern_pkg::*;
#(
   parameter int unsigned WIDTH       = DEFAULT_WIDTH,
   parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] a
);

   localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VALUE);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_q;

   // Bit 0 toggles every cycle; bit n toggles when bits n-1..0 are all 1.
   assign w_carry[0] = 1'b1;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      counter_bit #(
         .RESET_BIT (LP_RESET[gi])
      ) u_bit (
         .clk     (clk),
         .rst_n   (rst),
         .i_carry (w_carry[gi]),
         .o_q     (w_q[gi]),
         .o_carry (w_carry[gi+1])
      );
   end : g_slice

   // Carry out of the MSB slice is the wrap indication; it is intentionally
   // left unused because the counter has no terminal-count flag.
   logic w_unused_carry;
   assign w_unused_carry = w_carry[WIDTH];

   assign a = w_q;

endmodule : part2_4bit_counter_modern

// File: tb/tb_part2_4bit_counter_modern.sv
module tb_part2_4bit_counter_modern;

   logic       clk;
   logic       rst;
   logic [3:0] a;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] val;
   } exp_t;

   exp_t exp_q[$];

   part2_4bit_counter_modern #(
      .WIDTH       (4),
      .RESET_VALUE (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .a   (a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Wait for the next rising edge and queue the count expected after it.
   task automatic step(input string tag, input logic [3:0] e);
      exp_t item;
      @(posedge clk);
      item.tag = tag;
      item.val = e;
      exp_q.push_back(item);
   endtask

   // Monitor: sample half a cycle after each edge.
   always @(negedge clk) begin
      exp_t item;
      if (exp_q.size() > 0) begin
         item = exp_q.pop_front();
         check(item.tag, a, item.val);
      end
   end

   // Pull reset low mid-cycle (clear of both edges) and verify it acts at once.
   task automatic assert_reset_now(input string tag);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check(tag, a, 4'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      logic [3:0] m;
      rst = 1'b0;
      #1 check("por", a, 4'd0);

      // Power-up: held in reset with clock running.
      for (int i = 0; i < 5; i++) step("hold_por", 4'd0);

      // Release and count through the wrap: 1..15, 0, 1.
      release_reset();
      m = 4'd0;
      for (int i = 1; i <= 17; i++) begin
         m = m + 4'd1;
         step((i == 16) ? "wrap0" : (i == 17) ? "wrap1" : "count", m);
      end

      // Advance to 6, then reset mid-count.
      for (int i = 0; i < 5; i++) begin
         m = m + 4'd1;
         step("to6", m);
      end
      assert_reset_now("midrst_imm");
      for (int i = 0; i < 4; i++) step("midrst_hold", 4'd0);

      // Re-release: restarts from 0 with no carry-over.
      release_reset();
      for (int i = 1; i <= 5; i++) step("rerel", 4'(i));

      // Repeated pulse: low 6 clocks, high 4 clocks, twice.
      for (int p = 0; p < 2; p++) begin
         assert_reset_now("pulse_imm");
         for (int i = 0; i < 6; i++) step("pulse_low", 4'd0);
         release_reset();
         for (int i = 1; i <= 4; i++) step("pulse_high", 4'(i));
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule : tb_part2_4bit_counter_modern
